// File: rtl/wb_arbiter_pkg.sv
// Shared types and default widths for the register-file write-back arbiter.
// Holds the write-back entry layout {rd, data} used by the arbiter and its FIFO.
package wb_arbiter_pkg;

  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_AW-1:0] rd;
    logic [DEF_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Slow-path write-back FIFO: push/pop, head, occupancy, full/empty flags and
// a per-slot valid/rd view used to build the pending-write mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int  AW      = DEF_AW,
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = wb_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  entry_t                       wdata,
  output entry_t                       head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             valid,
  output logic [DEPTH-1:0][AW-1:0]     rd_view
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]   = {1'b0, PW'(PW'(i) - rptr)} < count;
      rd_view[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, long-latency results
// queue in wb_fifo. Ports: alu_*, mdu_* in; WE3/A3/WD3, busy_mask, fifo_count,
// mdu_ready, waw_err out.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_AW,
  parameter int DATA_WIDTH    = DEF_DW,
  parameter int FIFO_DEPTH    = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_we,
  input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          mdu_valid,
  output logic                          mdu_ready,
  input  logic [ADDRESS_WIDTH-1:0]      mdu_rd,
  input  logic [DATA_WIDTH-1:0]         mdu_result,
  output logic                          WE3,
  output logic [ADDRESS_WIDTH-1:0]      A3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic [2**ADDRESS_WIDTH-1:0]   busy_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          waw_err
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  logic                                    push;
  logic                                    pop;
  logic                                    alu_v;
  logic                                    hit;
  logic                                    full;
  logic                                    empty;
  entry_t                                  head;
  entry_t                                  wdata;
  logic [FIFO_DEPTH-1:0]                   fvalid;
  logic [FIFO_DEPTH-1:0][ADDRESS_WIDTH-1:0] frd;

  assign mdu_ready = !full;
  assign alu_v     = alu_we && (alu_rd != '0);
  assign push      = !rst && mdu_valid && !full && (mdu_rd != '0);
  // empty is registered, so an entry pushed this cycle cannot pop yet.
  assign pop       = !rst && !alu_v && !empty;
  assign wdata     = '{rd: mdu_rd, data: mdu_result};

  wb_fifo #(
    .AW      (ADDRESS_WIDTH),
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wdata   (wdata),
    .head    (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty),
    .valid   (fvalid),
    .rd_view (frd)
  );

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fvalid[i] && (frd[i] == alu_rd)) hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WE3     <= 1'b0;
      A3      <= '0;
      WD3     <= '0;
      waw_err <= 1'b0;
    end else begin
      if (alu_v && hit) waw_err <= 1'b1;
      if (alu_v) begin
        WE3 <= 1'b1;
        A3  <= alu_rd;
        WD3 <= alu_result;
      end else if (pop) begin
        WE3 <= 1'b1;
        A3  <= head.rd;
        WD3 <= head.data;
      end else begin
        WE3 <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fvalid[i]) busy_mask[frd[i]] = 1'b1;
    end
    if (WE3) busy_mask[A3] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_we;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_result;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_rd;
  logic [DW-1:0] mdu_result;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [31:0]   busy_mask;
  logic [2:0]    fifo_count;
  logic          waw_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd;
  logic          m_waw;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_we     (alu_we),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_rd     (mdu_rd),
    .mdu_result (mdu_result),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .busy_mask  (busy_mask),
    .fifo_count (fifo_count),
    .waw_err    (waw_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (m_we) m[m_a] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of the rules: reset clears; ALU write wins; else oldest queued
  // entry is written; accepted nonzero mdu entries join the back of the queue.
  task automatic model_update();
    int pre;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_we = 0; m_a = '0; m_wd = '0; m_waw = 0;
      return;
    end
    pre = mq.size();
    if (alu_we && alu_rd != 0) begin
      foreach (mq[i]) if (mq[i].rd == alu_rd) m_waw = 1;
      m_we = 1; m_a = alu_rd; m_wd = alu_result;
    end else if (pre > 0) begin
      e = mq.pop_front();
      m_we = 1; m_a = e.rd; m_wd = e.data;
    end else begin
      m_we = 0;
    end
    if (mdu_valid && pre < DEPTH && mdu_rd != 0)
      mq.push_back('{rd: mdu_rd, data: mdu_result});
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    alu_we = 0; alu_rd = '0; alu_result = '0;
    mdu_valid = 0; mdu_rd = '0; mdu_result = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    clk_step();
    clk_step();
    n_cmp++;
    if (WE3 !== 1'b0 || A3 !== '0 || WD3 !== '0) begin
      n_bad++;
      $display("FAIL reset_out: WE3=%b A3=%0d WD3=%h want 0/0/0", WE3, A3, WD3);
    end
    n_cmp++;
    if (fifo_count !== 3'd0 || busy_mask !== 32'd0 || waw_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: cnt=%0d busy=%h waw=%b want 0/0/0", fifo_count, busy_mask, waw_err);
    end
    n_cmp++;
    if (mdu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", mdu_ready);
    end
    rst = 0;
  endtask

  task automatic test_alu_write();
    alu_we = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
    clk_step();
    idle();
    n_cmp++;
    if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL alu_write: WE3=%b A3=%0d WD3=%h want 1/5/deadbeef", WE3, A3, WD3);
    end
    n_cmp++;
    if (busy_mask[5] !== 1'b1) begin
      n_bad++;
      $display("FAIL alu_busy: got %b want 1", busy_mask[5]);
    end
    clk_step();
    n_cmp++;
    if (busy_mask[5] !== 1'b0 || WE3 !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_after: busy5=%b WE3=%b want 0/0", busy_mask[5], WE3);
    end
  endtask

  task automatic test_mdu_path();
    mdu_valid = 1; mdu_rd = 7; mdu_result = 32'h12345678;
    clk_step();
    idle();
    n_cmp++;
    if (fifo_count !== 3'd1 || WE3 !== 1'b0 || busy_mask[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL mdu_enq: cnt=%0d WE3=%b busy7=%b want 1/0/1", fifo_count, WE3, busy_mask[7]);
    end
    clk_step();
    n_cmp++;
    if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h12345678 || busy_mask[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL mdu_pop: WE3=%b A3=%0d WD3=%h busy7=%b want 1/7/12345678/1", WE3, A3, WD3, busy_mask[7]);
    end
    clk_step();
    n_cmp++;
    if (busy_mask[7] !== 1'b0 || fifo_count !== 3'd0) begin
      n_bad++;
      $display("FAIL mdu_done: busy7=%b cnt=%0d want 0/0", busy_mask[7], fifo_count);
    end
  endtask

  task automatic test_fill();
    int nxt = 1;
    int acc = 0;
    logic rdy;
    for (int c = 0; c < 6; c++) begin
      alu_we = 1; alu_rd = 10; alu_result = $urandom;
      mdu_valid = 1; mdu_rd = 5'(nxt); mdu_result = 32'h100 + nxt;
      rdy = mdu_ready;
      clk_step();
      if (rdy) begin acc++; nxt++; end
    end
    n_cmp++;
    if (acc != 4 || fifo_count !== 3'd4 || mdu_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill: accepts=%0d cnt=%0d ready=%b want 4/4/0", acc, fifo_count, mdu_ready);
    end
    idle();
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      n_cmp++;
      if (WE3 !== 1'b1 || A3 !== 5'(k) || WD3 !== 32'h100 + k) begin
        n_bad++;
        $display("FAIL drain%0d: WE3=%b A3=%0d WD3=%h want 1/%0d/%h", k, WE3, A3, WD3, k, 32'h100 + k);
      end
    end
    clk_step();
    n_cmp++;
    if (WE3 !== 1'b0 || fifo_count !== 3'd0 || mdu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_end: WE3=%b cnt=%0d ready=%b want 0/0/1", WE3, fifo_count, mdu_ready);
    end
  endtask

  task automatic test_x0();
    for (int c = 0; c < 4; c++) begin
      alu_we = 1; alu_rd = 0; alu_result = $urandom;
      mdu_valid = 1; mdu_rd = 0; mdu_result = $urandom;
      clk_step();
      n_cmp++;
      if (WE3 !== 1'b0 || fifo_count !== 3'd0) begin
        n_bad++;
        $display("FAIL x0_%0d: WE3=%b cnt=%0d want 0/0", c, WE3, fifo_count);
      end
    end
    idle();
  endtask

  task automatic test_waw();
    mdu_valid = 1; mdu_rd = 9; mdu_result = 32'hAAAA0009;
    clk_step();
    idle();
    alu_we = 1; alu_rd = 9; alu_result = 32'hBBBB0009;
    clk_step();
    idle();
    n_cmp++;
    if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'hBBBB0009 || waw_err !== 1'b1) begin
      n_bad++;
      $display("FAIL waw_alu: WE3=%b A3=%0d WD3=%h waw=%b want 1/9/bbbb0009/1", WE3, A3, WD3, waw_err);
    end
    clk_step();
    n_cmp++;
    if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'hAAAA0009) begin
      n_bad++;
      $display("FAIL waw_mdu: WE3=%b A3=%0d WD3=%h want 1/9/aaaa0009", WE3, A3, WD3);
    end
    clk_step();
    clk_step();
    n_cmp++;
    if (waw_err !== 1'b1) begin
      n_bad++;
      $display("FAIL waw_sticky: got %b want 1", waw_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      alu_we = 1; alu_rd = 3; alu_result = $urandom;
      mdu_valid = 1; mdu_rd = 5'(11 + c); mdu_result = $urandom;
      clk_step();
    end
    n_cmp++;
    if (fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL mid_fill: cnt=%0d want 3", fifo_count);
    end
    rst = 1;
    alu_rd = 4;
    clk_step();
    n_cmp++;
    if (fifo_count !== 3'd0 || WE3 !== 1'b0 || busy_mask !== 32'd0 || waw_err !== 1'b0 || mdu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: cnt=%0d WE3=%b busy=%h waw=%b rdy=%b want 0/0/0/0/1", fifo_count, WE3, busy_mask, waw_err, mdu_ready);
    end
    rst = 0;
    idle();
    for (int c = 0; c < 5; c++) begin
      clk_step();
      n_cmp++;
      if (WE3 !== 1'b0 || fifo_count !== 3'd0) begin
        n_bad++;
        $display("FAIL mid_after%0d: WE3=%b cnt=%0d want 0/0", c, WE3, fifo_count);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      alu_we     = ($urandom_range(0, 99) < 45);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_result = $urandom;
      mdu_valid  = ($urandom_range(0, 99) < 60);
      mdu_rd     = 5'($urandom_range(0, 7));
      mdu_result = $urandom;
      clk_step();
      n_cmp++;
      if (WE3 !== m_we || (m_we && (A3 !== m_a || WD3 !== m_wd))) begin
        n_bad++;
        $display("FAIL rnd_wr c=%0d: %b/%0d/%h want %b/%0d/%h", c, WE3, A3, WD3, m_we, m_a, m_wd);
      end
      n_cmp++;
      if (fifo_count !== 3'(mq.size()) || mdu_ready !== (mq.size() < DEPTH)) begin
        n_bad++;
        $display("FAIL rnd_cnt c=%0d: cnt=%0d rdy=%b want %0d", c, fifo_count, mdu_ready, mq.size());
      end
      n_cmp++;
      if (busy_mask !== model_busy() || waw_err !== m_waw) begin
        n_bad++;
        $display("FAIL rnd_busy c=%0d: busy=%h waw=%b want %h/%b", c, busy_mask, waw_err, model_busy(), m_waw);
      end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    m_we = 0; m_a = '0; m_wd = '0; m_waw = 0;
    test_reset();
    test_alu_write();
    test_mdu_path();
    test_fill();
    clk_step();
    test_x0();
    test_waw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter ADDRESS_WIDTH SHALL default to 5 and set the register index width.
REQ-003 Parameter DATA_WIDTH SHALL default to 32 and set the write-data width.
REQ-004 Parameter FIFO_DEPTH SHALL default to 4 and set the slow-path buffer entries; it SHALL be a power of two and at least 2.
REQ-005 Ports SHALL be exactly the following, one per line:
 clk  in  1  rising-edge clock
 rst  in  1  synchronous active-high reset
 alu_we  in  1  single-cycle ALU result valid; has no backpressure
 alu_rd  in  ADDRESS_WIDTH  ALU destination register
 alu_result  in  DATA_WIDTH  ALU write data
 mdu_valid  in  1  long-latency unit (mul/div/load) result valid
 mdu_ready  out  1  slow-path accept; high when FIFO not full
 mdu_rd  in  ADDRESS_WIDTH  long-latency destination register
 mdu_result  in  DATA_WIDTH  long-latency write data
 WE3  out  1  register-file write enable, registered
 A3  out  ADDRESS_WIDTH  register-file write address, registered
 WD3  out  DATA_WIDTH  register-file write data, registered
 busy_mask  out  2**ADDRESS_WIDTH  per-register pending-write flags
 fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
 waw_err  out  1  sticky write-after-write ordering violation flag

Function
REQ-006 The block SHALL drive the register-file write port; the register file itself does not enforce x0, so writes with rd=0 SHALL be dropped here.
REQ-007 An mdu handshake SHALL occur on a rising edge with mdu_valid=1 and mdu_ready=1; an accepted rd=0 entry SHALL be discarded and not enqueued.
REQ-008 mdu_ready SHALL be a registered-state function equal to (fifo_count < FIFO_DEPTH) and SHALL NOT depend combinationally on mdu_valid.
REQ-009 Arbitration SHALL give priority to the ALU: with alu_we=1 and alu_rd!=0, the next WE3/A3/WD3 SHALL be 1/alu_rd/alu_result.
REQ-010 Otherwise, when the FIFO is non-empty, the head entry SHALL be popped and presented as the next WE3=1/A3/WD3.
REQ-011 Otherwise, the next WE3 SHALL be 0, and A3/WD3 SHALL hold their previous values.
REQ-012 ALU-to-WE3 latency SHALL be 1 cycle. mdu-to-WE3 latency SHALL be at least 2 cycles (enqueue then pop); there SHALL be no bypass path.
REQ-013 The FIFO SHALL drain in acceptance order; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 A simultaneous push and pop SHALL leave fifo_count unchanged; a push into an empty FIFO SHALL NOT pop in the same cycle.
REQ-015 When the FIFO is full, pushes SHALL be impossible (mdu_ready=0), and pops SHALL proceed only on cycles with no valid ALU write.
REQ-016 busy_mask bit r SHALL be 1 iff any valid FIFO entry has rd=r, or WE3=1 and A3=r; bit 0 SHALL always be 0.
REQ-017 waw_err SHALL be set and held until reset when alu_we=1, alu_rd!=0, and any valid FIFO entry has rd=alu_rd; the ALU write SHALL still be performed.

Reset
REQ-018 On rst=1 at a rising edge, the FIFO SHALL be emptied (fifo_count=0) and pointers set to 0.
REQ-019 On the same reset edge, WE3=0, A3=0, WD3=0, waw_err=0 and busy_mask=0; mdu_ready SHALL be 1 in the first cycle after reset.
REQ-020 Reset mid-operation SHALL discard all queued entries without emitting any write; inputs SHALL be ignored while rst=1.

Structure
REQ-021 A shared package SHALL hold ADDRESS_WIDTH/DATA_WIDTH defaults and the typedef wb_entry_t {rd, data}.
REQ-022 The FIFO SHALL be a sub-module named wb_fifo exposing push, pop, head, count, full, empty, and a per-entry valid/rd view for busy_mask.

Verification
REQ-023 Scenario: alu_we=1, rd=5, data=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF, and busy_mask[5]=1 for exactly that cycle.
REQ-024 Scenario: mdu rd=7, data=0x12345678 with ALU idle -> fifo_count=1 after 1 cycle; WE3=1, A3=7 after 2 cycles; busy_mask[7] high across both cycles.
REQ-025 Scenario: ALU writes every cycle while mdu pushes rd=1..5 -> mdu_ready drops after 4 accepts with fifo_count=4; entries then drain in order 1,2,3,4 once ALU idles.
REQ-026 Scenario: alu rd=0 and mdu rd=0 -> WE3 never asserts, and fifo_count stays 0.
REQ-027 Scenario: queue mdu rd=9, then alu rd=9 -> waw_err=1 and it stays set; ALU write emitted first, then the mdu write.
REQ-028 Scenario: assert rst with 3 entries queued -> next cycle fifo_count=0, WE3=0, busy_mask=0, and no queued write ever appears.
